// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetches 16-bit instruction words, decodes the opcode and hands
// each unit instruction (LOAD/ADD/SUB/MOVE) to its operation FSM with a one-cycle
// start pulse, then waits for that unit's done before advancing the pc.
// Build option: define SEQ_TIMEOUT_EN to bound the WAIT state to TIMEOUT cycles;
// on expiry the sequencer flags err and halts.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | stopped, waiting for run
// FETCH    | latch imem_data into ir
// DECODE   | latch Ri/Rj, pick the unit, or handle NOP/HALT/illegal
// DISPATCH | unit_start pulses for the selected unit
// WAIT     | hold until the selected unit reports done
// ADVANCE  | pc+1, continue to FETCH or stop in IDLE depending on run
// HALTED   | absorbing; only reset leaves
module cpu_sequencer #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [3:0]      unit_start,
    input  logic [3:0]      unit_done,
    output logic [5:0]      Ri,
    output logic [5:0]      Rj,
    output logic            busy,
    output logic            halted,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_WAIT,
        S_ADVANCE,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("cpu_sequencer: TIMEOUT must be in 1..255");
    end

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [3:0]      sel;
    logic [3:0]      opcode;
    logic [3:0]      dec_unit;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT);
    logic [7:0] wait_cnt;
`endif

    assign opcode    = ir[15:12];
    assign imem_addr = pc;

    // Opcode to one-hot unit select; zero means "not a unit instruction".
    always_comb begin
        dec_unit = 4'b0000;
        case (opcode)
            4'h1:    dec_unit = 4'b0001;
            4'h2:    dec_unit = 4'b0010;
            4'h3:    dec_unit = 4'b0100;
            4'h7:    dec_unit = 4'b1000;
            default: dec_unit = 4'b0000;
        endcase
    end

    // Sequencer FSM; outputs are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            sel        <= '0;
            Ri         <= '0;
            Rj         <= '0;
            unit_start <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            err        <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else begin
            unit_start <= 4'b0000;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir    <= imem_data;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    Ri  <= ir[11:6];
                    Rj  <= ir[5:0];
                    sel <= dec_unit;
                    if (dec_unit != 4'b0000) begin
                        state      <= S_DISPATCH;
                        unit_start <= dec_unit;
                    end else if (opcode == OP_NOP) begin
                        state <= S_ADVANCE;
                    end else begin
                        // HALT and illegal opcodes both stop here without touching pc.
                        state  <= S_HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        if (opcode != OP_HALT) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_DISPATCH: begin
                    state <= S_WAIT;
`ifdef SEQ_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if ((unit_done & sel) != 4'b0000) begin
                        state <= S_ADVANCE;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (wait_cnt + 8'd1 == TIMEOUT_TC) begin
                        state  <= S_HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        err    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`else
                    // Without the timeout the unit may take as long as it likes.
`endif
                end
                S_ADVANCE: begin
                    pc <= pc + 1'b1;
                    if (run) begin
                        state <= S_FETCH;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction sequencer for the simple CPU. It fetches 16-bit instruction words from instruction memory and decodes the opcode. It then dispatches a one-cycle start pulse to the matching operation FSM (LOAD, ADD, SUB, MOVE), waits for that unit's done, and advances the program counter. It sits above the per-opcode FSMs and is the only block that drives their start inputs and Ri/Rj operand fields.

## Interface
- PC_W, 8, program counter and instruction-address width
- TIMEOUT, 15, WAIT-state cycle limit (1..255); used only with SEQ_TIMEOUT_EN
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  level enable; sampled in IDLE and ADVANCE
- imem_addr  out  PC_W  instruction address, always equal to pc
- imem_data  in  16  instruction word, combinational read of imem_addr
- unit_start  out  4  one-hot start; bit0 LOAD, bit1 ADD, bit2 SUB, bit3 MOVE
- unit_done  in  4  done from each unit, same bit mapping
- Ri  out  6  destination field, registered from ir[11:6]
- Rj  out  6  source field, registered from ir[5:0]
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  high in HALTED
- err  out  1  sticky error flag; cleared only by reset

## Operation
- Instruction format: [15:12] opcode, [11:6] Ri, [5:0] Rj.
- Opcode decode:
  - 0x0 NOP
  - 0x1 LOAD
  - 0x2 ADD
  - 0x3 SUB
  - 0x7 MOVE
  - 0xF HALT
  - every other value is illegal.
- States: IDLE, FETCH, DECODE, DISPATCH, WAIT, ADVANCE, HALTED.
- IDLE: if run=1, go to FETCH; otherwise stay.
- FETCH: ir <= imem_data; go to DECODE.
- DECODE: Ri/Rj <= ir fields. Next state by opcode:
  - unit opcode -> DISPATCH
  - NOP -> ADVANCE
  - HALT -> HALTED; pc is not incremented
  - illegal -> err <= 1, then HALTED.
- DISPATCH: unit_start = one-hot of the decoded unit for exactly this cycle; go to WAIT.
- WAIT: stay until unit_done[sel]=1. Then go to ADVANCE.
  - unit_done bits of non-selected units are ignored.
  - unit_done is ignored in every state other than WAIT.
- ADVANCE: pc <= pc+1, modulo 2^PC_W (255 -> 0 wraps silently). Go to FETCH if run=1, otherwise IDLE.
- HALTED: absorbing state; only reset leaves it.
- Dropping run mid-instruction never aborts it. The current instruction completes and the block stops in IDLE after ADVANCE.
- Ri/Rj hold their values from DECODE until the next DECODE.

## Timing
- Reset values (next edge with reset=1, any state):
  - state=IDLE, pc=0, ir=0
  - Ri=0, Rj=0
  - unit_start=0, busy=0, halted=0, err=0
  - timeout counter=0
- unit_start, busy and halted are decoded from state (Moore outputs). unit_start is never high outside DISPATCH.
- NOP costs 3 cycles: FETCH, DECODE, ADVANCE.
- A unit op costs 4+N cycles, where N is the number of WAIT cycles (N >= 1).
  - Example: a unit that raises done 2 cycles after sampling start gives N=1, 5 cycles total.
- If unit_done[sel] is already high on the first WAIT cycle, it is accepted. ADVANCE follows on the next cycle.
- Reset in WAIT or DISPATCH takes effect at that edge; any in-flight unit handshake is abandoned.

## Configuration
- SEQ_TIMEOUT_EN defined: an 8-bit counter clears on WAIT entry and increments each WAIT cycle without done.
  - If it reaches TIMEOUT with no done, the block sets err=1 and goes to HALTED on that edge.
  - A done that arrives on the same cycle as the limit wins; the instruction advances normally.
- SEQ_TIMEOUT_EN undefined: no counter is instantiated and WAIT lasts indefinitely. err is set only by an illegal opcode.

## Test plan
- MOVE dispatch:
  - stimulus: run=1, imem[0]=0x7042; Move-style unit returns done 2 cycles after start
  - expect: unit_start=4'b1000 for one cycle, Ri=1, Rj=2, pc=1 five cycles after FETCH, then fetch from address 1.
- NOP run to halt:
  - stimulus: imem[0..2]=0x0000, imem[3]=0xF000
  - expect: pc steps 0,1,2,3 every 3 cycles; halted=1 with pc=3; no unit_start ever high; busy=0 afterwards.
- Illegal opcode:
  - stimulus: imem[0]=0x5000
  - expect: err=1 and halted=1 on the cycle after DECODE; unit_start stays 0; held until reset.
- Wrong and late done:
  - stimulus: ADD 0x2000; during WAIT assert unit_done=4'b1000 for 3 cycles, then 4'b0010
  - expect: the block stays in WAIT through the wrong done and advances only on bit1.
- Timeout (macro on, TIMEOUT=15):
  - stimulus: ADD with unit_done tied 0
  - expect: err=1, halted=1 after 15 WAIT cycles.
  - with the macro off: busy stays 1 for at least 100 cycles.
- Reset, run-drop and wrap:
  - reset asserted mid-WAIT: all outputs at reset values next edge.
  - run dropped during DISPATCH: instruction completes, then IDLE with pc incremented.
  - pc preloaded to 255 via NOPs: wraps to 0.
